// File: rtl/input_loader_pkg.sv
// Shared types for the top-level sequencer
// and the stages it drives.
package input_loader_pkg;

  typedef enum logic [2:0] {
    s_IDLE    = 3'd0,
    s_LOAD    = 3'd1,
    s_LAYER_1 = 3'd2,
    s_LAYER_2 = 3'd3,
    s_LAYER_3 = 3'd4
  } state_t;

endpackage

// File: rtl/input_loader.sv
// Input loader: assembles the binary image and
// the 3x3x8 kernel set from a byte stream.
module input_loader
  import input_loader_pkg::*;
#(
  parameter int IMG_DIM     = 28,
  parameter int NUM_FILTERS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  state_t     state,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic [IMG_DIM-1:0][IMG_DIM-1:0] pixels,
  output logic [2:0][2:0][NUM_FILTERS-1:0] weights,
  output logic       load_done,
  output logic       overflow_err
);

  localparam int PIX_BITS  = IMG_DIM * IMG_DIM;
  localparam int PIX_BYTES = (PIX_BITS + 7) / 8;
  localparam int WT_BYTES  = 9;
  localparam int LAST      = PIX_BYTES + WT_BYTES - 1;

  logic [6:0] byte_cnt;
  logic [PIX_BYTES*8-1:0] pix_flat;
  logic [WT_BYTES*NUM_FILTERS-1:0] wt_flat;
  logic in_load;
  logic accept;

  assign in_load    = (state == s_LOAD);
  assign data_ready = in_load && !load_done;
  assign accept     = data_valid && data_ready;

  assign pixels  = pix_flat[PIX_BITS-1:0];
  assign weights = wt_flat;

  // Capture one byte per accepting edge into the
  // pixel or weight region selected by byte_cnt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_flat <= '0;
      wt_flat  <= '0;
    end else if (accept) begin
      for (int i = 0; i < PIX_BYTES; i++) begin
        if (byte_cnt == 7'(i))
          pix_flat[i*8 +: 8] <= data_in;
      end
      for (int k = 0; k < WT_BYTES; k++) begin
        if (byte_cnt == 7'(PIX_BYTES + k))
          wt_flat[k*NUM_FILTERS +: NUM_FILTERS] <= data_in;
      end
    end
  end

  // Byte counter saturates at the last byte;
  // load_done latches on the final accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt  <= '0;
      load_done <= 1'b0;
    end else if (accept) begin
      if (byte_cnt == 7'(LAST))
        load_done <= 1'b1;
      else
        byte_cnt <= byte_cnt + 7'd1;
    end
  end

  // Any byte offered after completion is dropped
  // and flagged until reset.
  always_ff @(posedge clk) begin
    if (!rst_n)
      overflow_err <= 1'b0;
    else if (in_load && load_done && data_valid)
      overflow_err <= 1'b1;
  end

endmodule
